// File: rtl/aud_btm_rx_pkg.sv
// Shared definitions for the AUD branch-trace receiver: FSM encodings,
// frame-length limit, status-register bit indices and address helpers.
package aud_btm_rx_pkg;

    typedef enum logic [1:0] {
        AUD_BTM_IDLE    = 2'd0,
        AUD_BTM_COLLECT = 2'd1,
        AUD_BTM_DRAIN   = 2'd2
    } aud_btm_state_e;

    localparam int AUD_BTM_MAX_NIB   = 8;
    localparam int AUD_SR_BTM_ERRLEN = 0;
    localparam int AUD_SR_BTM_OVR    = 1;

    function automatic logic len_ok(input logic [3:0] cnt);
        return (cnt == 4'd1) || (cnt == 4'd2) || (cnt == 4'd4) || (cnt == 4'd8);
    endfunction

    // Compressed frames replace only the low nibbles of the previous address.
    function automatic logic [31:0] compose(input logic [31:0] last,
                                            input logic [31:0] nibs,
                                            input logic [3:0]  cnt);
        case (cnt)
            4'd1:    return {last[31:4],  nibs[3:0]};
            4'd2:    return {last[31:8],  nibs[7:0]};
            4'd4:    return {last[31:16], nibs[15:0]};
            default: return nibs;
        endcase
    endfunction

endpackage

// File: rtl/aud_btm_rx_sync_edge.sv
// Two-flop synchronizer for the AUD pin bundle plus a registered rising-edge
// detector on AUD_CK; nsync/data are registered alongside the tick.
module aud_btm_rx_sync_edge (
    input  logic       clk_sys_i,
    input  logic       rst_n_i,
    input  logic       aud_ck_i,
    input  logic       aud_nsync_i,
    input  logic [3:0] aud_data_i,
    output logic       tick_o,
    output logic       nsync_o,
    output logic [3:0] data_o
);

    logic [5:0] pins_p0, pins_p1;
    logic       ck_prev_p2;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pins_p0    <= '0;
            pins_p1    <= '0;
            ck_prev_p2 <= 1'b0;
            tick_o     <= 1'b0;
            nsync_o    <= 1'b1;
            data_o     <= '0;
        end else begin
            pins_p0    <= {aud_ck_i, aud_nsync_i, aud_data_i};
            // synchronized stage -> edge-detect stage
            pins_p1    <= pins_p0;
            ck_prev_p2 <= pins_p1[5];
            tick_o     <= pins_p1[5] & ~ck_prev_p2;
            nsync_o    <= pins_p1[4];
            data_o     <= pins_p1[3:0];
        end
    end

endmodule

// File: rtl/aud_btm_rx.sv
// AUD branch-trace receiver: reassembles 1/2/4/8-nibble compressed branch
// addresses into 32-bit words on a valid/ready stream. AUD_BTM_TSTAMP_EN adds frame timestamps.
module aud_btm_rx
    import aud_btm_rx_pkg::*;
(
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        aud_ck_i,
    input  logic        aud_nsync_i,
    input  logic [3:0]  aud_data_i,
    output logic [31:0] addr_o,
    output logic [3:0]  nib_o,
    output logic [15:0] tstamp_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        idle_o,
    output logic        err_len_o,
    output logic        overrun_o
);

    logic           tick, nsync;
    logic [3:0]     data;
    aud_btm_state_e state;
    logic [3:0]     cnt;
    logic [31:0]    nib_buf, last_addr, frame_addr;
    logic           accept, load_word;

    aud_btm_rx_sync_edge u_sync (
        .clk_sys_i  (clk_sys_i),
        .rst_n_i    (rst_n_i),
        .aud_ck_i   (aud_ck_i),
        .aud_nsync_i(aud_nsync_i),
        .aud_data_i (aud_data_i),
        .tick_o     (tick),
        .nsync_o    (nsync),
        .data_o     (data)
    );

    assign frame_addr = compose(last_addr, nib_buf, cnt);
    assign accept     = !valid_o || ready_i;
    assign load_word  = en_i && tick && (state == AUD_BTM_COLLECT) && nsync
                        && len_ok(cnt) && accept;
    assign idle_o     = (state == AUD_BTM_IDLE) && !valid_o;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= AUD_BTM_IDLE;
            cnt       <= '0;
            nib_buf   <= '0;
            last_addr <= '0;
            addr_o    <= '0;
            nib_o     <= '0;
            valid_o   <= 1'b0;
            err_len_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (valid_o && ready_i)
                valid_o <= 1'b0;
            // clear first so a same-cycle flag set below takes priority
            if (clr_i) begin
                err_len_o <= 1'b0;
                overrun_o <= 1'b0;
                last_addr <= '0;
            end
            if (!en_i) begin
                state <= AUD_BTM_IDLE;
                cnt   <= '0;
            end else if (tick) begin
                case (state)
                    AUD_BTM_IDLE: begin
                        if (!nsync) begin
                            nib_buf[3:0] <= data;
                            cnt          <= 4'd1;
                            state        <= AUD_BTM_COLLECT;
                        end
                    end
                    AUD_BTM_COLLECT: begin
                        if (!nsync) begin
                            if (cnt < 4'(AUD_BTM_MAX_NIB)) begin
                                nib_buf[{cnt[2:0], 2'b00} +: 4] <= data;
                                cnt <= cnt + 4'd1;
                            end else begin
                                err_len_o <= 1'b1;
                                state     <= AUD_BTM_DRAIN;
                            end
                        end else begin
                            state <= AUD_BTM_IDLE;
                            cnt   <= '0;
                            if (len_ok(cnt)) begin
                                // track the address even when the word is dropped
                                last_addr <= frame_addr;
                                if (accept) begin
                                    addr_o  <= frame_addr;
                                    nib_o   <= cnt;
                                    valid_o <= 1'b1;
                                end else begin
                                    overrun_o <= 1'b1;
                                end
                            end else begin
                                err_len_o <= 1'b1;
                            end
                        end
                    end
                    AUD_BTM_DRAIN: begin
                        if (nsync) begin
                            state <= AUD_BTM_IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: state <= AUD_BTM_IDLE;
                endcase
            end
        end
    end

`ifdef AUD_BTM_TSTAMP_EN
    logic [15:0] cyc_cnt, frame_ts, tstamp_q;
    logic        frame_start;

    assign frame_start = en_i && tick && (state == AUD_BTM_IDLE) && !nsync;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_cnt  <= '0;
            frame_ts <= '0;
            tstamp_q <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
            if (frame_start)
                frame_ts <= cyc_cnt;
            if (load_word)
                tstamp_q <= frame_ts;
        end
    end

    assign tstamp_o = tstamp_q;
`else
    logic unused_load;
    assign unused_load = load_word;
    assign tstamp_o    = '0;
`endif

endmodule

// File: tb/tb_aud_btm_rx.sv
// Scoreboard bench for aud_btm_rx: directed AUD frames, expected words queued
// at issue time and checked by an independent monitor on each accepted transfer.
module tb_aud_btm_rx;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, ck, nsync_pin, ready;
    logic [3:0]  data_pin;
    logic [31:0] addr;
    logic [3:0]  nib;
    logic [15:0] tstamp;
    logic        valid, idle, err_len, overrun;

    int total = 0;
    int bad   = 0;
    logic [35:0] exp_q[$];
    logic [15:0] ts_log[$];

    always #5 clk = ~clk;

    aud_btm_rx dut (
        .clk_sys_i  (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .clr_i      (clr),
        .aud_ck_i   (ck),
        .aud_nsync_i(nsync_pin),
        .aud_data_i (data_pin),
        .addr_o     (addr),
        .nib_o      (nib),
        .tstamp_o   (tstamp),
        .valid_o    (valid),
        .ready_i    (ready),
        .idle_o     (idle),
        .err_len_o  (err_len),
        .overrun_o  (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One AUD_CK period: 4 sys cycles low, rising edge, 4 sys cycles high.
    task automatic send_nib(input logic ns, input logic [3:0] d, input logic lat);
        nsync_pin = ns;
        data_pin  = d;
        ck        = 1'b0;
        repeat (4) @(negedge clk);
        ck = 1'b1;
        if (lat) begin
            repeat (3) @(negedge clk);
            chk("latency_pre", {31'd0, valid}, 32'd0);
            @(negedge clk);
            chk("latency_at4", {31'd0, valid}, 32'd1);
            @(negedge clk);
            chk("valid_one_cycle", {31'd0, valid}, 32'd0);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [31:0] val, input int n, input logic lat);
        for (int i = 0; i < n; i++)
            send_nib(1'b0, val[4*i +: 4], 1'b0);
        send_nib(1'b1, 4'h0, lat);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: %0d words still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every accepted transfer must match the oldest expected word.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got 0x%08h expected none", addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_addr", addr, e[31:0]);
                    chk("word_nib", {28'd0, nib}, {28'd0, e[35:32]});
`ifdef AUD_BTM_TSTAMP_EN
                    ts_log.push_back(tstamp);
`else
                    chk("word_tstamp", {16'd0, tstamp}, 32'd0);
`endif
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; ck = 1'b0;
        nsync_pin = 1'b1; data_pin = 4'h0; ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_addr",   addr, 32'd0);
        chk("rst_nib",    {28'd0, nib}, 32'd0);
        chk("rst_tstamp", {16'd0, tstamp}, 32'd0);
        chk("rst_valid",  {31'd0, valid}, 32'd0);
        chk("rst_idle",   {31'd0, idle}, 32'd1);
        chk("rst_err",    {31'd0, err_len}, 32'd0);
        chk("rst_ovr",    {31'd0, overrun}, 32'd0);
        repeat (3) @(negedge clk);

        // Full 8-nibble frame, then compressed 2- and 4-nibble frames
        exp_q.push_back({4'd8, 32'h8C001234});
        send_frame(32'h8C001234, 8, 1'b1);
        wait_drain("drain_full");
        exp_q.push_back({4'd2, 32'h8C00125A});
        send_frame(32'h0000005A, 2, 1'b0);
        wait_drain("drain_2nib");
        exp_q.push_back({4'd4, 32'h8C00BEEF});
        send_frame(32'h0000BEEF, 4, 1'b0);
        wait_drain("drain_4nib");

        // 3-nibble frame: error, no word, last address untouched
        send_frame(32'h00000123, 3, 1'b0);
        repeat (6) @(negedge clk);
        chk("err_len_3nib", {31'd0, err_len}, 32'd1);
        exp_q.push_back({4'd1, 32'h8C00BEE3});
        send_frame(32'h00000003, 1, 1'b0);
        wait_drain("drain_after_3nib");

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_err", {31'd0, err_len}, 32'd0);

        // 9-nibble frame plus an extra nibble while draining
        for (int i = 0; i < 10; i++)
            send_nib(1'b0, 4'(i), 1'b0);
        send_nib(1'b1, 4'h0, 1'b0);
        repeat (6) @(negedge clk);
        chk("err_len_9nib", {31'd0, err_len}, 32'd1);
        chk("idle_after_drain", {31'd0, idle}, 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_err2", {31'd0, err_len}, 32'd0);
        exp_q.push_back({4'd1, 32'h00000007});
        send_frame(32'h00000007, 1, 1'b0);
        wait_drain("drain_after_clr");

        // Backpressure: second frame overruns, first word stays presented
        ready = 1'b0;
        exp_q.push_back({4'd8, 32'h11223344});
        send_frame(32'h11223344, 8, 1'b0);
        send_frame(32'h00000066, 2, 1'b0);
        repeat (6) @(negedge clk);
        chk("ovr_hold_addr", addr, 32'h11223344);
        chk("ovr_valid", {31'd0, valid}, 32'd1);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        ready = 1'b1;
        wait_drain("drain_ovr");
        exp_q.push_back({4'd1, 32'h11223369});
        send_frame(32'h00000009, 1, 1'b0);
        wait_drain("drain_after_ovr");

        // Reset mid-frame after 3 nibbles
        for (int i = 0; i < 3; i++)
            send_nib(1'b0, 4'hA, 1'b0);
        rst_n = 1'b0;
        ck = 1'b0;
        nsync_pin = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr",  addr, 32'd0);
        chk("mid_rst_nib",   {28'd0, nib}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_idle",  {31'd0, idle}, 32'd1);
        chk("mid_rst_ovr",   {31'd0, overrun}, 32'd0);
        chk("mid_rst_err",   {31'd0, err_len}, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.push_back({4'd8, 32'hDEADBEEF});
        send_frame(32'hDEADBEEF, 8, 1'b0);
        wait_drain("drain_after_rst");

`ifdef AUD_BTM_TSTAMP_EN
        ts_log.delete();
        exp_q.push_back({4'd1, 32'hDEADBEE1});
        send_frame(32'h00000001, 1, 1'b0);
        repeat (84) @(negedge clk);
        exp_q.push_back({4'd1, 32'hDEADBEE2});
        send_frame(32'h00000002, 1, 1'b0);
        wait_drain("drain_tstamp");
        repeat (2) @(negedge clk);
        if (ts_log.size() == 2) begin
            chk("tstamp_delta", {16'd0, ts_log[1] - ts_log[0]}, 32'd100);
        end else begin
            total++;
            bad++;
            $display("FAIL tstamp_count: got %0d expected 2", ts_log.size());
        end
`endif

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
